// File: rtl/mem_responder.sv
// mem_responder: multi-cycle 16-bit word memory behind a valid/ready request port.
// It returns a single-cycle response strobe LATENCY cycles after a request is accepted.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic        rsp_wr,
  output logic [15:0] rsp_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // cnt_r counts the WAIT cycles still to go after the current one
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_s;
  logic                accept_s;
  logic                enter_resp_s;
  logic                wr_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [15:0]         wdata_r;
  logic                rsp_valid_r;
  logic                rsp_wr_r;
  logic [15:0]         rsp_rdata_r;
  logic [15:0]         mem_r [2**ADDR_W];
  logic                unused_addr_s;

  assign accept_s      = req_valid && (state_r == IDLE);
  assign unused_addr_s = ^{req_addr[15:ADDR_W+1], req_addr[0]};

  // Next-state and counter logic
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = WAIT;
          cnt_s   = CNT_INIT;
        end else begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_s = WAIT;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request capture so the initiator may change its inputs after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r    <= 1'b0;
      idx_r   <= '0;
      wdata_r <= 16'h0000;
    end else if (accept_s) begin
      wr_r    <= req_wr;
      idx_r   <= req_addr[ADDR_W:1];
      wdata_r <= req_wdata;
    end
  end

  // Storage is never cleared; a write lands only on the edge entering RESP
  always_ff @(posedge clk) begin
    if (enter_resp_s && wr_r) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  // Response registers; read data holds across write acknowledges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_wr_r    <= 1'b0;
      rsp_rdata_r <= 16'h0000;
    end else begin
      rsp_valid_r <= enter_resp_s;
      rsp_wr_r    <= enter_resp_s ? wr_r : 1'b0;
      if (enter_resp_s && !wr_r) begin
        rsp_rdata_r <= mem_r[idx_r];
      end
    end
  end

  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_wr    = rsp_wr_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (LATENCY 4 and 1) driven with directed
// and random traffic; expected responses are queued at issue time and checked by a monitor.
module tb_mem_responder;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  typedef struct {
    logic        wr;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_wr    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_wr    [2];
  logic [15:0] rsp_rdata [2];
  logic        busy      [2];

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] mem_m   [2][1024];
  logic [15:0] last_rd [2];
  int          last_acc[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_W(10), .LATENCY(LAT0)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_wr(req_wr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_wr(rsp_wr[0]), .rsp_rdata(rsp_rdata[0]),
    .busy(busy[0])
  );

  mem_responder #(.ADDR_W(10), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_wr(req_wr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_wr(rsp_wr[1]), .rsp_rdata(rsp_rdata[1]),
    .busy(busy[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input int i);
    check($sformatf("reset_ready%0d", i), 32'(req_ready[i]), 32'd1);
    check($sformatf("reset_busy%0d", i),  32'(busy[i]),      32'd0);
    check($sformatf("reset_valid%0d", i), 32'(rsp_valid[i]), 32'd0);
    check($sformatf("reset_wr%0d", i),    32'(rsp_wr[i]),    32'd0);
    check($sformatf("reset_rdata%0d", i), 32'(rsp_rdata[i]), 32'h0000);
  endtask

  task automatic drop_front(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with req_valid still high.
  task automatic send(input int i, input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                      input bit track, input bit chk_gap);
    int   guard;
    int   e;
    int   w;
    exp_t x;
    req_valid[i] = 1'b1;
    req_wr[i]    = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    guard = 0;
    while (!req_ready[i] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout inst%0d: req_ready stayed %b, expected 1", i, req_ready[i]);
      req_valid[i] = 1'b0;
      return;
    end
    e = cyc + 1;
    if (chk_gap) check($sformatf("accept_gap%0d", i), 32'(e - last_acc[i]), 32'(lat_of(i) + 2));
    last_acc[i] = e;
    if (track) begin
      w     = (int'(addr) / 2) % 1024;
      x.wr  = wr;
      x.due = e + lat_of(i);
      if (wr) begin
        mem_m[i][w] = wd;
        x.data      = last_rd[i];
      end else begin
        x.data     = mem_m[i][w];
        last_rd[i] = x.data;
      end
      if (i == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int i, input int n);
    req_valid[i] = 1'b0;
    req_addr[i]  = 16'($urandom);
    req_wdata[i] = 16'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic mon(input int i);
    exp_t x;
    bit   have;
    have = 1'b0;
    if (i == 0) begin
      if (q0.size() > 0) begin x = q0[0]; have = 1'b1; end
    end else begin
      if (q1.size() > 0) begin x = q1[0]; have = 1'b1; end
    end
    if (rsp_valid[i] === 1'b1) begin
      n_tests++;
      if (!have) begin
        n_fail++;
        $display("FAIL unexpected_rsp inst%0d: rsp_valid=1 at cycle %0d, expected no response", i, cyc);
      end else begin
        drop_front(i);
        if (x.due != cyc || rsp_wr[i] !== x.wr || rsp_rdata[i] !== x.data) begin
          n_fail++;
          $display("FAIL rsp inst%0d: got cycle %0d wr %b data %h, expected cycle %0d wr %b data %h",
                   i, cyc, rsp_wr[i], rsp_rdata[i], x.due, x.wr, x.data);
        end
      end
    end else if (have && cyc > x.due) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_rsp inst%0d: no response by cycle %0d, expected at %0d", i, cyc, x.due);
      drop_front(i);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    logic [9:0]  pool [8];
    logic [4:0]  hi;
    logic        b0;
    int          gap;
    int          k;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_wr[i] = 1'b0; req_addr[i] = 16'h0000; req_wdata[i] = 16'h0000;
      last_rd[i] = 16'h0000; last_acc[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Write BEEF, check the RESP cycle blocks requests and IDLE returns one cycle later
    send(0, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b0);
    idle(0, LAT0);
    check("resp_cycle_ready", 32'(req_ready[0]), 32'd0);
    check("resp_cycle_busy",  32'(busy[0]),      32'd1);
    idle(0, 1);
    check("after_resp_ready", 32'(req_ready[0]), 32'd1);
    check("after_resp_busy",  32'(busy[0]),      32'd0);

    // Read it back, then a write acknowledge must leave rsp_rdata at BEEF
    send(0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0);
    send(0, 1'b1, 16'h0044, 16'h7777, 1'b1, 1'b1);
    idle(0, 7);
    check("rdata_hold", 32'(rsp_rdata[0]), 32'h0000BEEF);

    // Preload 1,2,3 then hold req_valid across three reads
    send(0, 1'b1, 16'h0000, 16'h0001, 1'b1, 1'b0);
    send(0, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b1);
    send(0, 1'b1, 16'h0004, 16'h0003, 1'b1, 1'b1);
    idle(0, 7);
    send(0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    send(0, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b1);
    send(0, 1'b0, 16'h0004, 16'h0000, 1'b1, 1'b1);
    idle(0, 7);

    // Reset two cycles into a write: no response, old contents kept
    send(0, 1'b1, 16'h0020, 16'h5555, 1'b1, 1'b0);
    idle(0, 7);
    send(0, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0);
    idle(0, 1);
    rst_n = 1'b0;
    #1;
    check_reset(0);
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(0, 8);
    send(0, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0);
    idle(0, 7);

    // LATENCY 1: aliasing of upper address bits, back-to-back spacing
    send(1, 1'b1, 16'h0010, 16'hCAFE, 1'b1, 1'b0);
    idle(1, 3);
    send(1, 1'b0, 16'h0810, 16'h0000, 1'b1, 1'b0);
    send(1, 1'b0, 16'hF811, 16'h0000, 1'b1, 1'b1);
    idle(1, 4);

    // Random traffic on both instances over a small aliased address pool
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 8; p++) begin
        pool[p] = 10'($urandom);
        send(i, 1'b1, {5'd0, pool[p], 1'b0}, 16'($urandom), 1'b1, 1'b0);
      end
      idle(i, 6);
      for (int n = 0; n < 40; n++) begin
        k   = int'($urandom_range(0, 7));
        hi  = 5'($urandom);
        b0  = 1'($urandom);
        gap = int'($urandom_range(0, 2));
        if (gap > 0) idle(i, gap);
        send(i, 1'($urandom), {hi, pool[k], b0}, 16'($urandom), 1'b1, (gap == 0 && n > 0));
      end
      idle(i, 8);
    end

    idle(0, 10);
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
